sd_data_check: RTL and testbench

SD_DATA_CHECK -- requirements
Module: sd_data_check

---
 rtl/sd_data_check.sv | 137 +++++++++++++
 tb/tb_sd_data_check.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sd_data_check.sv
// SD card data self-test: writes an incrementing word pattern to one sector,
// reads it back, and reports mismatches, short reads or a stalled controller.
module sd_data_check #(
  parameter logic [31:0] SEC_ADDR = 32'd2000,
  parameter logic [15:0] WORDS    = 16'd256,
  parameter logic [23:0] TIMEOUT  = 24'd10_000_000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        sd_init_done,
  output logic        wr_start_en,
  output logic [31:0] wr_sec_addr,
  input  logic        wr_data_req,
  output logic [15:0] wr_data,
  input  logic        wr_busy,
  output logic        rd_start_en,
  output logic [31:0] rd_sec_addr,
  input  logic        rd_val_en,
  input  logic [15:0] rd_val_data,
  input  logic        rd_busy,
  output logic        error_flag,
  output logic        test_done
);

  typedef enum logic [2:0] {
    IDLE, WR_START, WR_WAIT, RD_START, RD_WAIT, DONE
  } state_e;

  state_e      state_q;
  logic        wr_start_q, rd_start_q, err_q, done_q, busy_seen_q;
  logic [15:0] wr_data_q;
  logic [15:0] exp_q, exp_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [23:0] wd_q;
  logic        wd_expired;

  assign wr_sec_addr = SEC_ADDR;
  assign rd_sec_addr = SEC_ADDR;
  assign wr_start_en = wr_start_q;
  assign rd_start_en = rd_start_q;
  assign wr_data     = wr_data_q;
  assign error_flag  = err_q;
  assign test_done   = done_q;

  // Read-side counters are computed ahead so a final word arriving with the
  // busy fall is already included in the pass/fail decision.
  always_comb begin
    exp_d     = exp_q;
    rd_cnt_d  = rd_cnt_q;
    err_cnt_d = err_cnt_q;
    if (state_q == RD_WAIT && rd_val_en) begin
      if (rd_val_data != exp_q && err_cnt_q != 16'hFFFF)
        err_cnt_d = err_cnt_q + 16'd1;
      exp_d    = exp_q + 16'd1;
      rd_cnt_d = rd_cnt_q + 16'd1;
    end
  end

  assign wd_expired = !busy_seen_q && (wd_q == TIMEOUT - 24'd1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wr_start_q  <= 1'b0;
      rd_start_q  <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_seen_q <= 1'b0;
      wr_data_q   <= 16'd0;
      exp_q       <= 16'd0;
      rd_cnt_q    <= 16'd0;
      err_cnt_q   <= 16'd0;
      wd_q        <= 24'd0;
    end else begin
      wr_start_q <= 1'b0;
      rd_start_q <= 1'b0;
      exp_q      <= exp_d;
      rd_cnt_q   <= rd_cnt_d;
      err_cnt_q  <= err_cnt_d;
      case (state_q)
        IDLE: begin
          if (sd_init_done) begin
            state_q    <= WR_START;
            wr_start_q <= 1'b1;
          end
        end
        WR_START: begin
          state_q     <= WR_WAIT;
          wr_data_q   <= 16'd0;
          wd_q        <= 24'd0;
          busy_seen_q <= 1'b0;
        end
        WR_WAIT: begin
          if (wr_data_req) wr_data_q <= wr_data_q + 16'd1;
          if (!busy_seen_q) wd_q <= wd_q + 24'd1;
          if (wd_expired) begin
            state_q <= DONE;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
          end else if (busy_seen_q && !wr_busy) begin
            state_q     <= RD_START;
            rd_start_q  <= 1'b1;
            busy_seen_q <= 1'b0;
          end else if (wr_busy) begin
            busy_seen_q <= 1'b1;
          end
        end
        RD_START: begin
          state_q     <= RD_WAIT;
          exp_q       <= 16'd0;
          rd_cnt_q    <= 16'd0;
          wd_q        <= 24'd0;
          busy_seen_q <= 1'b0;
        end
        RD_WAIT: begin
          if (!busy_seen_q) wd_q <= wd_q + 24'd1;
          if (wd_expired) begin
            state_q <= DONE;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
          end else if (busy_seen_q && !rd_busy) begin
            state_q     <= DONE;
            busy_seen_q <= 1'b0;
            done_q      <= 1'b1;
            err_q       <= (err_cnt_d != 16'd0) || (rd_cnt_d != WORDS);
          end else if (rd_busy) begin
            busy_seen_q <= 1'b1;
          end
        end
        DONE: state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_data_check.sv
// Directed scenarios with randomized handshake gaps, checked against a
// sector-level model of what a correct write/read-back test must report.
module tb_sd_data_check;
  localparam logic [31:0] SEC = 32'd2000;
  localparam int NW = 256;
  localparam int TO = 100;

  logic        clock = 1'b0, reset_n = 1'b0, sd_init_done = 1'b0;
  logic        wr_data_req = 1'b0, wr_busy = 1'b0;
  logic        rd_val_en = 1'b0, rd_busy = 1'b0;
  logic [15:0] rd_val_data = 16'd0;
  logic        wr_start_en, rd_start_en, error_flag, test_done;
  logic [31:0] wr_sec_addr, rd_sec_addr;
  logic [15:0] wr_data;

  int n_cmp = 0;
  int n_bad = 0;

  sd_data_check #(.SEC_ADDR(SEC), .WORDS(16'd256), .TIMEOUT(24'(TO))) dut (
    .clock(clock), .reset_n(reset_n), .sd_init_done(sd_init_done),
    .wr_start_en(wr_start_en), .wr_sec_addr(wr_sec_addr),
    .wr_data_req(wr_data_req), .wr_data(wr_data), .wr_busy(wr_busy),
    .rd_start_en(rd_start_en), .rd_sec_addr(rd_sec_addr),
    .rd_val_en(rd_val_en), .rd_val_data(rd_val_data), .rd_busy(rd_busy),
    .error_flag(error_flag), .test_done(test_done)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    wr_data_req = 1'b0; wr_busy = 1'b0;
    rd_val_en = 1'b0; rd_busy = 1'b0; rd_val_data = 16'd0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; sd_init_done = 1'b0; idle_inputs();
    repeat (3) @(negedge clock);
    chk("rst_outputs", {wr_start_en, rd_start_en, error_flag, test_done}, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_addr", wr_sec_addr, SEC);
    chk("rst_rd_addr", rd_sec_addr, SEC);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  // Raise init, model the write controller, finish at the first RD_WAIT cycle.
  task automatic do_write();
    int t, consumed, bad;
    sd_init_done = 1'b1;
    t = 0;
    @(negedge clock);
    while (!wr_start_en && t < 20) begin @(negedge clock); t++; end
    chk("wr_start_seen", wr_start_en, 1);
    chk("flags_pre_done_wr", {test_done, error_flag}, 0);
    @(negedge clock);
    chk("wr_start_width", wr_start_en, 0);
    chk("wr_data_entry", wr_data, 0);
    wr_busy = 1'b1;
    consumed = 0; bad = 0;
    while (consumed < NW) begin
      if ($urandom_range(3) != 0) begin
        wr_data_req = 1'b1;
        if (wr_data !== 16'(consumed)) bad++;
        consumed++;
      end else begin
        wr_data_req = 1'b0;
      end
      @(negedge clock);
    end
    wr_data_req = 1'b0;
    chk("wr_seq_errors", bad, 0);
    chk("wr_data_final", wr_data, 16'(NW));
    repeat ($urandom_range(1, 4)) @(negedge clock);
    chk("rd_start_early", rd_start_en, 0);
    wr_busy = 1'b0;
    t = 0;
    @(negedge clock);
    while (!rd_start_en && t < 10) begin @(negedge clock); t++; end
    chk("rd_start_seen", rd_start_en, 1);
    @(negedge clock);
    chk("rd_start_width", rd_start_en, 0);
  endtask

  // Model the read controller returning n words, word cidx replaced by cval.
  task automatic do_read(input int n, input int cidx, input logic [15:0] cval,
                         input bit same_cycle, input string tag);
    int  sent;
    bit  exp_err;
    exp_err = (n != NW) || (cidx >= 0 && cidx < n && cval != 16'(cidx));
    rd_busy = 1'b1;
    sent = 0;
    while (sent < n) begin
      if ($urandom_range(3) != 0) begin
        rd_val_en   = 1'b1;
        rd_val_data = (sent == cidx) ? cval : 16'(sent);
        sent++;
        if (same_cycle && sent == n) rd_busy = 1'b0;
      end else begin
        rd_val_en   = 1'b0;
        rd_val_data = 16'($urandom);
      end
      wr_data_req = 1'($urandom_range(1));
      @(negedge clock);
      if (rd_busy) chk({tag, "_pre_done"}, {test_done, error_flag}, 0);
    end
    rd_val_en = 1'b0; wr_data_req = 1'b0;
    if (!same_cycle) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      rd_busy = 1'b0;
      @(negedge clock);
    end
    chk({tag, "_done"}, test_done, 1);
    chk({tag, "_err"}, error_flag, 32'(exp_err));
    chk({tag, "_wr_hold"}, wr_data, 16'(NW));
    sd_init_done = 1'b0;
    rd_busy = 1'b1; rd_val_en = 1'b1; wr_busy = 1'b1;
    repeat (3) @(negedge clock);
    chk({tag, "_terminal"}, {test_done, error_flag}, {1'b1, exp_err});
    idle_inputs();
  endtask

  initial begin
    int cidx, cnt;
    bit saw_rd;
    logic [15:0] cval;

    do_reset();
    do_write();
    do_read(NW, -1, 16'd0, 1'b0, "pass");

    do_reset();
    do_write();
    do_read(NW, 100, 16'h00AA, 1'b0, "corrupt100");

    do_reset();
    do_write();
    do_read(NW - 1, -1, 16'd0, 1'b0, "short");

    do_reset();
    do_write();
    do_read(NW, -1, 16'd0, 1'b1, "same_cycle");

    do_reset();
    do_write();
    cidx = $urandom_range(NW - 1);
    cval = 16'(cidx) ^ 16'($urandom_range(1, 65535));
    do_read(NW, cidx, cval, 1'b1, "corrupt_rand");

    // Write controller never goes busy: the watchdog must end the test.
    do_reset();
    sd_init_done = 1'b1;
    cnt = 0;
    @(negedge clock);
    while (!wr_start_en && cnt < 20) begin @(negedge clock); cnt++; end
    chk("wd_wr_start", wr_start_en, 1);
    @(negedge clock);
    cnt = 0; saw_rd = 1'b0;
    while (!test_done && cnt < 3 * TO) begin
      if (rd_start_en) saw_rd = 1'b1;
      wr_data_req = 1'($urandom_range(1));
      cnt++;
      @(negedge clock);
    end
    wr_data_req = 1'b0;
    chk("wd_cycles", cnt, TO);
    chk("wd_done", test_done, 1);
    chk("wd_err", error_flag, 1);
    chk("wd_no_rd_start", saw_rd, 0);

    // Reset in the middle of a read, then a full clean run must follow.
    do_reset();
    do_write();
    rd_busy = 1'b1;
    for (int i = 0; i < 50; i++) begin
      rd_val_en = 1'b1; rd_val_data = 16'(i);
      @(negedge clock);
    end
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("midrd_rst_outputs", {wr_start_en, rd_start_en, error_flag, test_done}, 0);
    chk("midrd_rst_wr_data", wr_data, 0);
    chk("midrd_rst_addr", wr_sec_addr ^ rd_sec_addr ^ SEC, SEC);
    @(negedge clock);
    idle_inputs();
    @(negedge clock);
    reset_n = 1'b1;
    do_write();
    do_read(NW, -1, 16'd0, 1'b0, "restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
